// File: rtl/alu_cmd_seq_pkg.sv
// Shared types and constants for the alu16b command sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: default operand/opcode widths, opcode constants, sequencer
// FSM state encoding and the command layout at default widths.
package alu_pkg;

  localparam int ALU_DW  = 8;
  localparam int ALU_OPW = 8;

  localparam logic [ALU_OPW-1:0] OP_NOP = 8'h00;
  localparam logic [ALU_OPW-1:0] OP_ADD = 8'h80;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } seq_state_t;

  // Command layout at the default widths; the sequencer rebuilds the same
  // field order with its own parameter widths.
  typedef struct packed {
    logic [ALU_OPW-1:0] opcode;
    logic [ALU_DW-1:0]  a;
    logic [ALU_DW-1:0]  b;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO holding queued ALU commands, DEPTH entries of W bits.
// Latency: pushed entry visible at o_pop_dat one cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored.
//
// Ports: clk/rst (sync, active-high), i_push/i_push_dat write side,
// i_pop/o_pop_dat read side (head is shown combinationally),
// o_full/o_empty/o_count occupancy status.
module alu_cmd_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_push_dat,
  input  logic                     i_pop,
  output logic [W-1:0]             o_pop_dat,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_pop_dat = r_mem[r_rd_ptr];

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

endmodule

// File: rtl/alu_cmd_seq.sv
// Command sequencer feeding alu16b: queues commands, issues one at a time, returns tagged results.
// Latency: accept at E0, ALU driven after E1, rsp_valid after E0+ALU_LAT+2 (empty FIFO).
// Backpressure: cmd_ready drops when the FIFO is full; rsp_ready low holds the result and stalls issue.
//
// Ports: clk/rst (sync, active-high); cmd_* valid/ready command input;
// alu_opcode/alu_a/alu_b registered drive to alu16b, alu_z its result;
// rsp_* valid/ready result output tagged with the opcode; busy/fifo_count status.
module alu_cmd_seq
  import alu_pkg::*;
#(
  parameter int DW      = ALU_DW,
  parameter int OPW     = ALU_OPW,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [OPW-1:0]          cmd_opcode,
  input  logic [DW-1:0]           cmd_a,
  input  logic [DW-1:0]           cmd_b,
  output logic [OPW-1:0]          alu_opcode,
  output logic [DW-1:0]           alu_a,
  output logic [DW-1:0]           alu_b,
  input  logic [DW-1:0]           alu_z,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DW-1:0]           rsp_z,
  output logic [OPW-1:0]          rsp_opcode,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int LATW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
  localparam logic [LATW-1:0] LAT_INIT = LATW'(ALU_LAT);
  localparam logic [OPW-1:0]  NOP      = OPW'(OP_NOP);

  typedef struct packed {
    logic [OPW-1:0] opcode;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
  } seq_cmd_t;

  seq_state_t             r_state;
  seq_state_t             w_state_nxt;
  logic [LATW-1:0]        r_wait_cnt;
  logic [OPW-1:0]         r_alu_opcode;
  logic [DW-1:0]          r_alu_a;
  logic [DW-1:0]          r_alu_b;
  logic                   r_rsp_valid;
  logic [DW-1:0]          r_rsp_z;
  logic [OPW-1:0]         r_rsp_opcode;

  seq_cmd_t               w_push_cmd;
  seq_cmd_t               w_head_cmd;
  logic                   w_push;
  logic                   w_full;
  logic                   w_empty;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_issue;
  logic                   w_capture;
  logic                   w_rsp_done;

  // Ready comes only from the registered count, so a full FIFO refuses a
  // command even on the edge that pops an entry.
  assign cmd_ready  = !rst && !w_full;
  assign w_push     = cmd_valid && cmd_ready;
  assign w_push_cmd = {cmd_opcode, cmd_a, cmd_b};

  alu_cmd_fifo #(
    .W     (OPW + 2*DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (w_push_cmd),
    .i_pop      (w_issue),
    .o_pop_dat  (w_head_cmd),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic. rsp_valid is high for the whole of RESP, so rsp_ready
  // there is the response handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (!w_empty) w_state_nxt = S_WAIT;
      S_WAIT: if (r_wait_cnt == '0) w_state_nxt = S_RESP;
      S_RESP: if (rsp_ready) w_state_nxt = w_empty ? S_IDLE : S_WAIT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control outputs. Issue from RESP happens on the handshake edge so the
  // next command starts back-to-back with the returned result.
  always_comb begin
    w_issue    = 1'b0;
    w_capture  = 1'b0;
    w_rsp_done = 1'b0;
    case (r_state)
      S_IDLE: w_issue = !w_empty;
      S_WAIT: w_capture = (r_wait_cnt == '0);
      S_RESP: begin
        w_rsp_done = rsp_ready;
        w_issue    = rsp_ready && !w_empty;
      end
      default: ;
    endcase
  end

  // Datapath: ALU drive, wait counter and response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt   <= '0;
      r_alu_opcode <= NOP;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_z      <= '0;
      r_rsp_opcode <= '0;
    end else begin
      if (w_issue) begin
        r_alu_opcode <= w_head_cmd.opcode;
        r_alu_a      <= w_head_cmd.a;
        r_alu_b      <= w_head_cmd.b;
        r_wait_cnt   <= LAT_INIT;
      end else if (r_state == S_WAIT && r_wait_cnt != '0) begin
        r_wait_cnt <= r_wait_cnt - LATW'(1);
      end

      // Operands are left in place after capture; only the opcode returns
      // to NOP so the ALU sees no live command while idle.
      if (w_capture) begin
        r_rsp_z      <= alu_z;
        r_rsp_opcode <= r_alu_opcode;
        r_rsp_valid  <= 1'b1;
        r_alu_opcode <= NOP;
      end else if (w_rsp_done) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign alu_opcode = r_alu_opcode;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_z      = r_rsp_z;
  assign rsp_opcode = r_rsp_opcode;
  assign fifo_count = w_count;
  assign busy       = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Self-checking bench for alu_cmd_seq with a registered add-only ALU model.
// Latency: n/a (bench).
// Backpressure: rsp_ready is driven per scenario, including random stalls.
module tb_alu_cmd_seq;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_opcode;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [7:0] alu_opcode;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_z;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_z;
  logic [7:0] rsp_opcode;
  logic       busy;
  logic [2:0] fifo_count;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  // Registered ALU, one edge from stable inputs to z.
  always_ff @(posedge clk) begin
    alu_z <= (alu_opcode == OP_ADD) ? alu_a + alu_b : 8'h00;
  end

  alu_cmd_seq #(.DW(8), .OPW(8), .DEPTH(4), .ALU_LAT(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_z      (alu_z),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_z      (rsp_z),
    .rsp_opcode (rsp_opcode),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  // Advance one clock. Handshakes visible before the edge update the
  // scoreboard: accepted commands push {opcode, a+b}, returned results pop.
  task automatic cycle();
    logic [15:0] exp;
    logic [7:0]  sum;
    if (rst) begin
      sb_q.delete();
    end else begin
      if (cmd_valid && cmd_ready) begin
        sum = cmd_a + cmd_b;
        sb_q.push_back({cmd_opcode, (cmd_opcode == OP_ADD) ? sum : 8'h00});
      end
      if (rsp_valid && rsp_ready) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: got opcode=%h z=%h, required no response", rsp_opcode, rsp_z);
        end else begin
          exp = sb_q.pop_front();
          if ({rsp_opcode, rsp_z} !== exp) begin
            n_err++;
            $display("FAIL sb_result: got opcode=%h z=%h, required opcode=%h z=%h",
                     rsp_opcode, rsp_z, exp[15:8], exp[7:0]);
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    int t;
    cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b;
    t = 0;
    while (!cmd_ready && t < 50) begin cycle(); t++; end
    n_vec++;
    if (!cmd_ready) begin
      n_err++;
      $display("FAIL push_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, t);
    end else begin
      cycle();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    rsp_ready = 1'b1;
    t = 0;
    while ((busy || sb_q.size() != 0) && t < 100) begin cycle(); t++; end
    n_vec++;
    if (sb_q.size() != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL drain: busy=%b pending=%0d, required busy=0 pending=0", busy, sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_opcode = 8'h00; cmd_a = 8'h00; cmd_b = 8'h00;
    for (int i = 0; i < 10; i++) cycle();
    n_vec++;
    if ({alu_opcode, alu_a, alu_b} !== 24'h0) begin
      n_err++;
      $display("FAIL rst_alu: got op=%h a=%h b=%h, required 00 00 00", alu_opcode, alu_a, alu_b);
    end
    n_vec++;
    if ({rsp_valid, rsp_z, rsp_opcode} !== 17'h0) begin
      n_err++;
      $display("FAIL rst_rsp: got valid=%b z=%h op=%h, required 0 00 00", rsp_valid, rsp_z, rsp_opcode);
    end
    n_vec++;
    if ({fifo_count, busy, cmd_ready} !== 5'h0) begin
      n_err++;
      $display("FAIL rst_status: got count=%0d busy=%b ready=%b, required 0 0 0", fifo_count, busy, cmd_ready);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_release: got ready=%b busy=%b, required ready=1 busy=0", cmd_ready, busy);
    end
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    push_cmd(OP_ADD, 8'd5, 8'd3);
    n_vec++;
    if (fifo_count !== 3'd1 || busy !== 1'b1 || alu_opcode !== 8'h00) begin
      n_err++;
      $display("FAIL single_accept: got count=%0d busy=%b op=%h, required 1 1 00", fifo_count, busy, alu_opcode);
    end
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_vec++;
      if ({alu_opcode, alu_a, alu_b} !== {8'h80, 8'd5, 8'd3} || rsp_valid !== 1'b0) begin
        n_err++;
        $display("FAIL single_drive%0d: got op=%h a=%h b=%h rsp_valid=%b, required 80 05 03 0",
                 i, alu_opcode, alu_a, alu_b, rsp_valid);
      end
    end
    cycle();
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_z !== 8'd8 || rsp_opcode !== 8'h80 || alu_opcode !== 8'h00) begin
      n_err++;
      $display("FAIL single_rsp: got valid=%b z=%h op=%h alu_op=%h, required 1 08 80 00",
               rsp_valid, rsp_z, rsp_opcode, alu_opcode);
    end
    cycle();
    n_vec++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_onecycle: got valid=%b busy=%b, required 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_stall();
    int last;
    int seen;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(OP_ADD, 8'(i), 8'd1);
    n_vec++;
    if (fifo_count !== 3'd4 || cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL stall_full: got count=%0d ready=%b, required 4 0", fifo_count, cmd_ready);
    end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_z !== 8'd1 || rsp_opcode !== 8'h80 || fifo_count !== 3'd4) begin
        n_err++;
        $display("FAIL stall_hold%0d: got valid=%b z=%h op=%h count=%0d, required 1 01 80 4",
                 i, rsp_valid, rsp_z, rsp_opcode, fifo_count);
      end
      cycle();
    end
    rsp_ready = 1'b1;
    last = -1;
    seen = 0;
    for (int t = 0; t < 40 && seen < 5; t++) begin
      if (rsp_valid) begin
        if (last >= 0) begin
          n_vec++;
          if (t - last != 3) begin
            n_err++;
            $display("FAIL stall_spacing: got %0d cycles between results, required 3", t - last);
          end
        end
        last = t;
        seen++;
      end
      cycle();
    end
    n_vec++;
    if (seen != 5 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL stall_count: got %0d results busy=%b, required 5 results busy=0", seen, busy);
    end
  endtask

  task automatic test_wrap();
    int sent;
    int got;
    logic acc;
    logic hs;
    sent = 0;
    got = 0;
    cmd_valid = 1'b1; cmd_opcode = OP_ADD;
    cmd_a = 8'($urandom_range(0, 255)); cmd_b = 8'($urandom_range(0, 255));
    for (int t = 0; t < 600 && got < 10; t++) begin
      rsp_ready = ($urandom_range(0, 2) != 0);
      if (sent >= 10) cmd_valid = 1'b0;
      acc = cmd_valid && cmd_ready;
      hs  = rsp_valid && rsp_ready;
      cycle();
      if (acc) begin
        sent++;
        cmd_a = 8'($urandom_range(0, 255));
        cmd_b = 8'($urandom_range(0, 255));
      end
      if (hs) got++;
    end
    cmd_valid = 1'b0;
    n_vec++;
    if (sent != 10 || got != 10 || sb_q.size() != 0) begin
      n_err++;
      $display("FAIL wrap_total: got sent=%0d results=%0d pending=%0d, required 10 10 0",
               sent, got, sb_q.size());
    end
  endtask

  task automatic test_full_pushpop();
    int t;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(OP_ADD, 8'(8'h40 + i), 8'h02);
    t = 0;
    while (!rsp_valid && t < 20) begin cycle(); t++; end
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_opcode = OP_ADD; cmd_a = 8'h10; cmd_b = 8'h20;
    n_vec++;
    if (cmd_ready !== 1'b0 || fifo_count !== 3'd4 || rsp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL full_refuse: got ready=%b count=%0d rsp_valid=%b, required 0 4 1",
               cmd_ready, fifo_count, rsp_valid);
    end
    cycle();
    rsp_ready = 1'b0;
    n_vec++;
    if (cmd_ready !== 1'b1 || fifo_count !== 3'd3) begin
      n_err++;
      $display("FAIL full_after_pop: got ready=%b count=%0d, required 1 3", cmd_ready, fifo_count);
    end
    cycle();
    cmd_valid = 1'b0;
    n_vec++;
    if (fifo_count !== 3'd4) begin
      n_err++;
      $display("FAIL full_accept: got count=%0d, required 4", fifo_count);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int stray;
    rsp_ready = 1'b1;
    push_cmd(OP_ADD, 8'h11, 8'h22);
    push_cmd(OP_ADD, 8'h33, 8'h44);
    push_cmd(OP_ADD, 8'h55, 8'h66);
    n_vec++;
    if (fifo_count !== 3'd2 || alu_opcode !== 8'h80 || rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_setup: got count=%0d alu_op=%h rsp_valid=%b, required 2 80 0",
               fifo_count, alu_opcode, rsp_valid);
    end
    rst = 1'b1;
    cycle();
    n_vec++;
    if (rsp_valid !== 1'b0 || fifo_count !== 3'd0 || alu_opcode !== 8'h00 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: got rsp_valid=%b count=%0d alu_op=%h busy=%b, required 0 0 00 0",
               rsp_valid, fifo_count, alu_opcode, busy);
    end
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) stray++;
      cycle();
    end
    n_vec++;
    if (stray != 0) begin
      n_err++;
      $display("FAIL mid_dropped: got %0d response cycles after reset, required 0", stray);
    end
    push_cmd(OP_ADD, 8'h7f, 8'h01);
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_wrap();
    test_full_pushpop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
